// File: rtl/ps2_key_event_queue_if.sv
// Byte-stream input and key-event pop port of the PS/2 key event queue.
// master: the queue itself; slave: the byte source plus event consumer.
interface ps2_key_event_queue_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              rx_done_tick;
    logic [7:0]        rx_byte;
    logic              ev_valid;
    logic              ev_ready;
    logic [9:0]        ev_data;
    logic [ADDR_W:0]   ev_count;
    logic              overflow;
    logic              proto_err;

    modport master (
        input  rx_done_tick, rx_byte, ev_ready,
        output ev_valid, ev_data, ev_count, overflow, proto_err
    );

    modport slave (
        output rx_done_tick, rx_byte, ev_ready,
        input  ev_valid, ev_data, ev_count, overflow, proto_err
    );
endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser (E0/F0 prefixes) feeding a small key-event FIFO.
// Events are {ext, brk, code[7:0]}; the consumer pops with valid/ready.
module ps2_key_event_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic                   clk,
    input logic                   reset,
    ps2_key_event_queue_if.master bus
);
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StPfE0, StPfF0, StPfE0F0} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               is_e0, is_f0, is_bad, timeout;
    logic               push, err_set;
    logic [9:0]         push_data;

    logic [9:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]    count_q;
    logic               overflow_q, proto_err_q;
    logic               full, do_push, do_pop;

    assign is_e0  = (bus.rx_byte == 8'hE0);
    assign is_f0  = (bus.rx_byte == 8'hF0);
    assign is_bad = (bus.rx_byte == 8'h00) || (bus.rx_byte == 8'hFF);

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (state_q != StIdle) && !bus.rx_done_tick && (tmo_cnt_q == CNT_LAST);

    // Parser state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Parser next-state: advances only on received bytes or prefix timeout
    always_comb begin
        state_d = state_q;
        if (bus.rx_done_tick) begin
            if (is_bad) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle:   if (is_e0) state_d = StPfE0;
                              else if (is_f0) state_d = StPfF0;
                    StPfE0:   if (is_f0) state_d = StPfE0F0;
                              else if (!is_e0) state_d = StIdle;
                    StPfF0:   if (is_e0) state_d = StPfE0F0;
                              else if (!is_f0) state_d = StIdle;
                    StPfE0F0: if (!is_e0 && !is_f0) state_d = StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end else if (timeout) begin
            state_d = StIdle;
        end
    end

    // Parser outputs: event push request, event word, protocol error strobe
    always_comb begin
        push      = bus.rx_done_tick && !is_bad && !is_e0 && !is_f0;
        push_data = {2'b00, bus.rx_byte};
        case (state_q)
            StPfE0:   push_data[9:8] = 2'b10;
            StPfF0:   push_data[9:8] = 2'b01;
            StPfE0F0: push_data[9:8] = 2'b11;
            default:  push_data[9:8] = 2'b00;
        endcase
        err_set = (bus.rx_done_tick && is_bad) || timeout;
    end

    // Prefix age counter: runs only while a prefix is pending
    always_comb begin
        if (bus.rx_done_tick || state_q == StIdle || timeout) tmo_cnt_d = '0;
        else                                                  tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end

    // FIFO control; a pop frees the slot a same-cycle push needs when full
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = bus.ev_valid && bus.ev_ready;
    assign do_push = push && (!full || do_pop);

    // FIFO storage; stale contents are masked by the pointers and ev_valid
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr_q] <= push_data;
    end

    // FIFO pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !do_push) overflow_q  <= 1'b1;
            if (err_set)          proto_err_q <= 1'b1;
        end
    end

    assign bus.ev_valid  = (count_q != '0);
    assign bus.ev_data   = bus.ev_valid ? mem[rd_ptr_q] : 10'h000;
    assign bus.ev_count  = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: fixed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_ps2_key_event_queue;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned TMO    = 20;

    logic clk;
    logic reset;

    ps2_key_event_queue_if #(.ADDR_W(ADDR_W)) bus ();

    ps2_key_event_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending prefix flags, age of pending prefix, event queue
    logic [9:0] m_q [$];
    bit         m_ext, m_brk, m_ovf, m_err;
    int         m_wait;

    typedef struct {
        bit         tick;
        logic [7:0] b;
        bit         rdy;
        bit         v;
        logic [9:0] d;
        int         c;
        bit         o;
        bit         e;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input bit v, input logic [9:0] d,
                              input int c, input bit o, input bit e);
        chk({name, ".valid"},     32'(bus.ev_valid),  32'(v));
        chk({name, ".data"},      32'(bus.ev_data),   32'(d));
        chk({name, ".count"},     32'(bus.ev_count),  32'(c));
        chk({name, ".overflow"},  32'(bus.overflow),  32'(o));
        chk({name, ".proto_err"}, 32'(bus.proto_err), 32'(e));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext  = 0;
        m_brk  = 0;
        m_ovf  = 0;
        m_err  = 0;
        m_wait = 0;
    endtask

    task automatic model_step(input bit t, input logic [7:0] b, input bit r);
        bit         have_ev;
        logic [9:0] ev;
        have_ev = 0;
        ev      = '0;
        if (m_q.size() > 0 && r) void'(m_q.pop_front());
        if (t) begin
            m_wait = 0;
            if (b == 8'h00 || b == 8'hFF) begin
                m_err = 1; m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                have_ev = 1;
                ev      = {m_ext, m_brk, b};
                m_ext   = 0;
                m_brk   = 0;
            end
        end else if (m_ext || m_brk) begin
            if (m_wait == int'(TMO) - 1) begin
                m_err = 1; m_ext = 0; m_brk = 0; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
        end
        if (have_ev) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(ev);
            else                         m_ovf = 1;
        end
    endtask

    task automatic check_model(input string name);
        logic [9:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 10'h000;
        check_outs(name, m_q.size() > 0, head, m_q.size(), m_ovf, m_err);
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge
    task automatic step(input bit t, input logic [7:0] b, input bit r);
        bus.rx_done_tick = t;
        bus.rx_byte      = b;
        bus.ev_ready     = r;
        model_step(t, b, r);
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.ev_ready     = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_done_tick = 1'b0;
        bus.ev_ready     = 1'b0;
        reset            = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int rdy_pct;
        bus.rx_done_tick = 1'b0;
        bus.rx_byte      = 8'h00;
        bus.ev_ready     = 1'b0;
        reset            = 1'b1;

        tbl[0]  = '{1, 8'h1C, 0, 1, 10'h01C, 1, 0, 0};
        tbl[1]  = '{1, 8'hF0, 0, 1, 10'h01C, 1, 0, 0};
        tbl[2]  = '{1, 8'h1C, 0, 1, 10'h01C, 2, 0, 0};
        tbl[3]  = '{0, 8'h00, 1, 1, 10'h11C, 1, 0, 0};
        tbl[4]  = '{0, 8'h00, 1, 0, 10'h000, 0, 0, 0};
        tbl[5]  = '{1, 8'hE0, 1, 0, 10'h000, 0, 0, 0};
        tbl[6]  = '{1, 8'h75, 1, 1, 10'h275, 1, 0, 0};
        tbl[7]  = '{1, 8'hE0, 1, 0, 10'h000, 0, 0, 0};
        tbl[8]  = '{1, 8'hF0, 1, 0, 10'h000, 0, 0, 0};
        tbl[9]  = '{1, 8'h75, 1, 1, 10'h375, 1, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 10'h000, 0, 0, 0};
        tbl[11] = '{1, 8'hFF, 0, 0, 10'h000, 0, 0, 1};

        do_reset();
        check_outs("reset", 0, 10'h000, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].tick, tbl[i].b, tbl[i].rdy);
            check_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].o, tbl[i].e);
        end

        // DEPTH+1 pushes with no consumer: last one dropped, order preserved
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 8'(8'h15 + i), 0);
        check_outs("ovf_fill", 1, 10'h015, 8, 1, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), 32'(bus.ev_data), 32'(10'h015 + i));
            step(0, 8'h00, 1);
        end
        check_outs("ovf_drained", 0, 10'h000, 0, 1, 0);

        // Full FIFO with push and pop in the same cycle: nothing dropped
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 8'(8'h15 + i), 0);
        check_outs("full8", 1, 10'h015, 8, 0, 0);
        step(1, 8'h2A, 1);
        check_outs("full_pushpop", 1, 10'h016, 8, 0, 0);
        step(1, 8'h1D, 0);
        check_outs("full_drop", 1, 10'h016, 8, 1, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_pop%0d", i), 32'(bus.ev_data),
                (i < 7) ? 32'(10'h016 + i) : 32'h02A);
            step(0, 8'h00, 1);
        end
        check_outs("full_drained", 0, 10'h000, 0, 1, 0);

        // Prefix abandoned by timeout: following code is a plain event
        do_reset();
        step(1, 8'hE0, 0);
        for (int i = 0; i < int'(TMO); i++) step(0, 8'h00, 0);
        check_outs("tmo_expired", 0, 10'h000, 0, 0, 1);
        step(1, 8'h1C, 0);
        check_outs("tmo_code", 1, 10'h01C, 1, 0, 1);

        // Byte landing on the expiry cycle still completes the prefix
        do_reset();
        step(1, 8'hE0, 0);
        for (int i = 0; i < int'(TMO) - 1; i++) step(0, 8'h00, 0);
        check_outs("tmo_edge_wait", 0, 10'h000, 0, 0, 0);
        step(1, 8'h1C, 0);
        check_outs("tmo_edge_code", 1, 10'h21C, 1, 0, 0);

        // Reset between prefix and code discards both prefix and queue
        do_reset();
        step(1, 8'h15, 0);
        step(1, 8'hE0, 0);
        do_reset();
        check_outs("mid_reset", 0, 10'h000, 0, 0, 0);
        step(1, 8'h75, 0);
        check_outs("mid_reset_code", 1, 10'h075, 1, 0, 0);
        step(0, 8'h00, 1);
        check_outs("mid_reset_pop", 0, 10'h000, 0, 0, 0);

        // Randomized traffic against the reference model
        do_reset();
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            int         sel;
            logic [7:0] b;
            bit         t;
            bit         r;
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 10;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            if ($urandom_range(0, 99) == 0) begin
                int len;
                len = $urandom_range(int'(TMO) - 3, int'(TMO) + 3);
                for (int k = 0; k < len; k++) begin
                    step(0, 8'h00, $urandom_range(0, 99) < rdy_pct);
                    check_model("rand_idle");
                end
            end
            sel = $urandom_range(0, 99);
            if (sel < 20)      b = 8'hE0;
            else if (sel < 35) b = 8'hF0;
            else if (sel < 37) b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
            else               b = 8'($urandom_range(1, 254));
            t = ($urandom_range(0, 99) < 45);
            r = ($urandom_range(0, 99) < rdy_pct);
            step(t, b, r);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
